// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch stage that keeps several in-order instruction-memory
// requests in flight and buffers the returned instructions in a small queue
// for decode. A PC redirect squashes everything queued and marks every
// in-flight fetch for discard. The retire-order tag is assigned only when
// decode accepts an instruction, so squashed fetches never use up a tag.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   stop_fetch_i     inhibit new imem requests (in-flight ones still complete)
//   redirect_valid_i squash and restart fetch at redirect_pc_i
//   redirect_pc_i    new fetch PC, 4-byte aligned
//   imem_req_o       request issued this cycle
//   imem_addr_o      request address (current fetch PC)
//   imem_rmask_o     4'hF while requesting, else 4'h0
//   imem_resp_i      in-order response strobe
//   imem_rdata_i     response instruction
//   dq_valid_o       queue head valid
//   dq_ready_i       decode accepts head
//   dq_pc_o          head PC
//   dq_pc_next_o     head PC + 4
//   dq_inst_o        head instruction
//   dq_order_o       retire-order tag of the head
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1eceb000,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stop_fetch_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [3:0]  imem_rmask_o,
  input  logic        imem_resp_i,
  input  logic [31:0] imem_rdata_i,
  output logic        dq_valid_o,
  input  logic        dq_ready_i,
  output logic [31:0] dq_pc_o,
  output logic [31:0] dq_pc_next_o,
  output logic [31:0] dq_inst_o,
  output logic [63:0] dq_order_o
);

  localparam int unsigned QAW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);

  localparam logic [CW-1:0]  DEPTH_C  = CW'(FQ_DEPTH);
  localparam logic [CW-1:0]  MAXOUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [TAW-1:0] TR_LAST  = TAW'(MAX_OUTSTANDING - 1);

  logic [31:0]    pc_q, pc_d;
  logic [63:0]    order_q, order_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  out_q, out_d;
  logic [CW-1:0]  discard_q, discard_d;
  logic [QAW-1:0] head_q, head_d;
  logic [QAW-1:0] tail_q, tail_d;
  logic [TAW-1:0] tr_rd_q, tr_rd_d;
  logic [TAW-1:0] tr_wr_q, tr_wr_d;

  logic [31:0] q_pc_q   [FQ_DEPTH];
  logic [31:0] q_inst_q [FQ_DEPTH];
  logic [31:0] tr_pc_q  [MAX_OUTSTANDING];

  logic issue, enq, deq;

  // Credit rule: in-flight requests plus queued entries never exceed the
  // queue depth, so every response always has a slot waiting for it.
  // Gated by reset so the request line drops the moment reset asserts.
  assign issue = rst_ni && !stop_fetch_i && !redirect_valid_i &&
                 (out_q < MAXOUT_C) &&
                 (({1'b0, out_q} + {1'b0, count_q}) < {1'b0, DEPTH_C});

  // A response is kept only when no squashed fetches are still draining and
  // no redirect is happening in the same cycle.
  assign enq = imem_resp_i && !redirect_valid_i && (discard_q == '0);
  assign deq = (count_q != '0) && dq_ready_i;

  assign imem_req_o   = issue;
  assign imem_addr_o  = pc_q;
  assign imem_rmask_o = issue ? 4'hF : 4'h0;

  assign dq_valid_o   = (count_q != '0);
  assign dq_pc_o      = q_pc_q[head_q];
  assign dq_pc_next_o = q_pc_q[head_q] + 32'd4;
  assign dq_inst_o    = q_inst_q[head_q];
  assign dq_order_o   = order_q;

  // Next-state logic. The PC tracker keeps popping on every response even
  // after a redirect so it stays aligned with the in-order memory replies.
  always_comb begin
    pc_d      = pc_q;
    order_d   = order_q;
    count_d   = count_q + (enq ? ONE_C : '0) - (deq ? ONE_C : '0);
    out_d     = out_q + (issue ? ONE_C : '0) - (imem_resp_i ? ONE_C : '0);
    discard_d = discard_q;
    head_d    = head_q;
    tail_d    = tail_q;
    tr_rd_d   = tr_rd_q;
    tr_wr_d   = tr_wr_q;

    if (issue) begin
      pc_d    = pc_q + 32'd4;
      tr_wr_d = (tr_wr_q == TR_LAST) ? '0 : tr_wr_q + TAW'(1);
    end
    if (imem_resp_i) begin
      tr_rd_d = (tr_rd_q == TR_LAST) ? '0 : tr_rd_q + TAW'(1);
    end
    if (deq) begin
      order_d = order_q + 64'd1;
      head_d  = head_q + QAW'(1);
    end
    if (enq) begin
      tail_d = tail_q + QAW'(1);
    end

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid_i) begin
      pc_d      = redirect_pc_i;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      discard_d = out_q - (imem_resp_i ? ONE_C : '0);
    end else if (imem_resp_i && (discard_q != '0)) begin
      discard_d = discard_q - ONE_C;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      order_q   <= '0;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      tr_rd_q   <= '0;
      tr_wr_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      order_q   <= order_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      tr_rd_q   <= tr_rd_d;
      tr_wr_q   <= tr_wr_d;
    end
  end

  // Data storage needs no reset; validity is tracked by the counters above.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      tr_pc_q[tr_wr_q] <= pc_q;
    end
    if (enq) begin
      q_pc_q[tail_q]   <= tr_pc_q[tr_rd_q];
      q_inst_q[tail_q] <= imem_rdata_i;
    end
  end

  // A response with nothing outstanding means the memory side is broken.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   imem_resp_i |-> (out_q != '0));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Drives fetch_queue_unit with directed scenarios followed by a random run,
// acting as an in-order instruction memory with configurable latency, and
// compares every cycle against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stop_fetch_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [3:0]  imem_rmask_o;
  logic        imem_resp_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        dq_valid_o;
  logic        dq_ready_i = 1'b0;
  logic [31:0] dq_pc_o;
  logic [31:0] dq_pc_next_o;
  logic [31:0] dq_inst_o;
  logic [63:0] dq_order_o;

  fetch_queue_unit #(
    .RESET_PC       (RESET_PC),
    .FQ_DEPTH       (DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .stop_fetch_i    (stop_fetch_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rmask_o    (imem_rmask_o),
    .imem_resp_i     (imem_resp_i),
    .imem_rdata_i    (imem_rdata_i),
    .dq_valid_o      (dq_valid_o),
    .dq_ready_i      (dq_ready_i),
    .dq_pc_o         (dq_pc_o),
    .dq_pc_next_o    (dq_pc_next_o),
    .dq_inst_o       (dq_inst_o),
    .dq_order_o      (dq_order_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: requests in flight (oldest first) and fetched entries.
  typedef struct {
    logic [31:0] pc;
    bit          squash;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        inflight[$];
  ent_t        fq[$];
  logic [31:0] expPc;
  logic [63:0] expOrder;
  bit          expReq;
  int          cyc;
  int          lat;

  bit          stopDrv, redirDrv, readyDrv, respDrv;
  logic [31:0] redirPcDrv;

  int assertions = 0;
  int failures   = 0;
  int reqSeen;

  // Arbitrary but deterministic memory contents.
  function automatic logic [31:0] instOf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    inflight.delete();
    fq.delete();
    expPc    = RESET_PC;
    expOrder = '0;
  endtask

  task automatic checkOutput();
    chk("imem_req", {63'd0, imem_req_o}, {63'd0, expReq});
    chk("imem_rmask", {60'd0, imem_rmask_o}, {60'd0, (expReq ? 4'hF : 4'h0)});
    if (expReq) chk("imem_addr", {32'd0, imem_addr_o}, {32'd0, expPc});
    chk("dq_valid", {63'd0, dq_valid_o}, {63'd0, (fq.size() != 0)});
    chk("dq_order", dq_order_o, expOrder);
    if (fq.size() != 0) begin
      chk("dq_pc", {32'd0, dq_pc_o}, {32'd0, fq[0].pc});
      chk("dq_pc_next", {32'd0, dq_pc_next_o}, {32'd0, fq[0].pc + 32'd4});
      chk("dq_inst", {32'd0, dq_inst_o}, {32'd0, fq[0].inst});
    end
    if (imem_req_o) reqSeen++;
  endtask

  // Advance the model across the clock edge that ends the current cycle.
  task automatic modelStep();
    req_t r;
    ent_t e;
    bit   deq;
    deq = (fq.size() != 0) && readyDrv;
    if (deq) begin
      e = fq.pop_front();
      expOrder = expOrder + 64'd1;
    end
    if (respDrv) begin
      r = inflight.pop_front();
      if (!r.squash && !redirDrv) fq.push_back('{r.pc, instOf(r.pc)});
    end
    if (redirDrv) begin
      fq.delete();
      foreach (inflight[i]) inflight[i].squash = 1'b1;
      expPc = redirPcDrv;
    end else if (expReq) begin
      inflight.push_back('{expPc, 1'b0, cyc + lat});
      expPc = expPc + 32'd4;
    end
    cyc++;
  endtask

  task automatic applyStimulus(input bit stop, input bit redir, input logic [31:0] rpc,
                               input bit ready);
    @(negedge clk_i);
    stopDrv    = stop;
    redirDrv   = redir;
    redirPcDrv = rpc;
    readyDrv   = ready;
    respDrv    = (inflight.size() != 0) && (inflight[0].due <= cyc);
    stop_fetch_i     = stop;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    dq_ready_i       = ready;
    imem_resp_i      = respDrv;
    imem_rdata_i     = respDrv ? instOf(inflight[0].pc) : 32'hDEADBEEF;
    expReq = !stop && !redir && (inflight.size() < MAXO) &&
             ((inflight.size() + fq.size()) < DEPTH);
    #1;
    checkOutput();
    modelStep();
  endtask

  // Assert reset between edges and confirm outputs collapse immediately.
  task automatic doReset();
    @(negedge clk_i);
    #2;
    rst_ni           = 1'b0;
    imem_resp_i      = 1'b0;
    redirect_valid_i = 1'b0;
    stop_fetch_i     = 1'b0;
    #1;
    chk("rst_imem_req", {63'd0, imem_req_o}, 64'd0);
    chk("rst_imem_rmask", {60'd0, imem_rmask_o}, 64'd0);
    chk("rst_dq_valid", {63'd0, dq_valid_o}, 64'd0);
    chk("rst_dq_order", dq_order_o, 64'd0);
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    bit found;
    modelReset();
    cyc = 0;
    lat = 1;

    // Reset release, 1-cycle memory, decode always ready.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Mid-stream reset with two requests outstanding.
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inflight.size() == 2) found = 1;
      else applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("two_outstanding_before_reset", {63'd0, found}, 64'd1);
    doReset();

    // Credit stall: decode never ready, exactly DEPTH requests go out.
    lat = 1;
    reqSeen = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    chk("credit_stall_reqs", reqSeen, 64'd4);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with two requests in flight under 3-cycle latency.
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inflight.size() == 2) found = 1;
      else applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("two_outstanding_before_redirect", {63'd0, found}, 64'd1);
    applyStimulus(1'b0, 1'b1, 32'h80000000, 1'b1);
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      if (dq_valid_o) begin
        found = 1;
        chk("redirect_first_pc", {32'd0, dq_pc_o}, 64'h80000000);
      end
    end
    chk("redirect_refill_seen", {63'd0, found}, 64'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect coinciding with a live response and a dq handshake.
    lat = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (inflight.size() != 0 && inflight[0].due <= cyc && !inflight[0].squash &&
          fq.size() != 0) begin
        found = 1;
        applyStimulus(1'b0, 1'b1, 32'h00004000, 1'b1);
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      end
    end
    chk("redirect_coincide_found", {63'd0, found}, 64'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // stop_fetch held for 5 cycles with two outstanding.
    lat = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inflight.size() == 2) found = 1;
      else applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("two_outstanding_before_stop", {63'd0, found}, 64'd1);
    reqSeen = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stop_no_reqs", reqSeen, 64'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(1, 4));
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                    $urandom() & 32'hFFFFFFFC, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
